// File: rtl/vga_text_console.sv
// Terminal-style write controller for the VGA text VRAM, port A.
// Bytes arrive over a valid/ready handshake and become char/attr writes at
// the cursor, with control codes, line wrap, full-screen clear and a
// hardware scroll that copies rows 1..ROWS-1 up by one row.
//
// Handshake: in_ready is high only in IDLE; a byte (in_data + in_attr) is
// taken on a rising edge where in_valid & in_ready, and busy = !in_ready.
module vga_text_console #(
  parameter int COLS   = 80,
  parameter int ROWS   = 45,
  parameter int ADDR_W = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                in_data,
  input  logic [7:0]                in_attr,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ADDR_W-1:0]         vram_address,
  output logic [7:0]                vram_in,
  output logic                      vram_write,
  input  logic [7:0]                vram_out,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic                      busy,
  output logic [2:0]                dbg_state
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int AW = 13;
  localparam logic [AW-1:0] ROW_BYTES   = AW'(COLS * 2);
  localparam logic [AW-1:0] SCROLL_LAST = AW'((ROWS - 1) * COLS * 2 - 1);
  localparam logic [AW-1:0] SCREEN_LAST = AW'(COLS * ROWS * 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PUT_CHAR  = 3'd1,
    S_PUT_ATTR  = 3'd2,
    S_SCROLL_RD = 3'd3,
    S_SCROLL_WR = 3'd4,
    S_CLEAR_W   = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [AW-1:0]  r_addr;     // byte pointer: cell address, scroll or clear index
  logic [7:0]     r_char;
  logic [7:0]     r_attr;
  logic           r_home;     // clear came from FF, so home the cursor at the end

  logic           w_accept;
  logic           w_is_print;
  logic           w_col_last;
  logic           w_row_last;
  logic [AW-1:0]  w_cell;
  logic [AW-1:0]  w_addr;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign w_col_last = (r_col == CW'(COLS - 1));
  assign w_row_last = (r_row == RW'(ROWS - 1));
  assign w_cell     = (AW'(r_row) * AW'(COLS) + AW'(r_col)) << 1;

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = !in_ready;
  assign cursor_col   = r_col;
  assign cursor_row   = r_row;
  assign dbg_state    = r_state;
  assign vram_address = {{(ADDR_W - AW){1'b0}}, w_addr};

  // State register; reset aborts any operation immediately.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and VRAM port A drive.
  always_comb begin
    w_next     = r_state;
    vram_write = 1'b0;
    w_addr     = '0;
    vram_in    = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_print)                          w_next = S_PUT_CHAR;
          else if (in_data == 8'h0A && w_row_last) w_next = S_SCROLL_RD;
          else if (in_data == 8'h0C)               w_next = S_CLEAR_W;
        end
      end
      S_PUT_CHAR: begin
        vram_write = 1'b1;
        w_addr     = r_addr;
        vram_in    = r_char;
        w_next     = S_PUT_ATTR;
      end
      S_PUT_ATTR: begin
        vram_write = 1'b1;
        w_addr     = r_addr + AW'(1);
        vram_in    = r_attr;
        w_next     = (w_col_last && w_row_last) ? S_SCROLL_RD : S_IDLE;
      end
      S_SCROLL_RD: begin
        w_addr = r_addr + ROW_BYTES;
        w_next = S_SCROLL_WR;
      end
      S_SCROLL_WR: begin
        vram_write = 1'b1;
        w_addr     = r_addr;
        vram_in    = vram_out;
        w_next     = (r_addr == SCROLL_LAST) ? S_CLEAR_W : S_SCROLL_RD;
      end
      S_CLEAR_W: begin
        vram_write = 1'b1;
        w_addr     = r_addr;
        vram_in    = r_addr[0] ? r_attr : 8'h20;
        if (r_addr == SCREEN_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Cursor, byte latches and the shared address counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
      r_char <= 8'h00;
      r_attr <= 8'h00;
      r_home <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_char <= in_data;
            r_attr <= in_attr;
            r_home <= (in_data == 8'h0C);
            r_addr <= w_is_print ? w_cell : '0;
            case (in_data)
              8'h0A: begin
                r_col <= '0;
                if (!w_row_last) r_row <= r_row + RW'(1);
              end
              8'h0D: r_col <= '0;
              8'h08: begin
                if (r_col != '0) begin
                  r_col <= r_col - CW'(1);
                end else if (r_row != '0) begin
                  r_col <= CW'(COLS - 1);
                  r_row <= r_row - RW'(1);
                end
              end
              default: ;
            endcase
          end
        end
        S_PUT_ATTR: begin
          if (w_col_last) begin
            r_col  <= '0;
            r_addr <= '0;
            if (!w_row_last) r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        S_SCROLL_WR: r_addr <= r_addr + AW'(1);
        S_CLEAR_W: begin
          if (r_addr == SCREEN_LAST) begin
            r_addr <= '0;
            if (r_home) begin
              r_col <= '0;
              r_row <= '0;
            end
          end else begin
            r_addr <= r_addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: a VRAM model on port A, directed byte
// sequences, and a write scoreboard fed by the stimulus side.
module tb_vga_text_console;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic [7:0]  in_attr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] vram_address;
  logic [7:0]  vram_in;
  logic        vram_write;
  logic [7:0]  vram_out;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [20:0] exp_q[$];   // {addr[12:0], data[7:0]}
  logic        mon_en  = 1'b0;
  logic        preload = 1'b0;
  logic [7:0]  mem [0:7199];

  vga_text_console dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_attr(in_attr),
    .in_valid(in_valid), .in_ready(in_ready), .vram_address(vram_address),
    .vram_in(vram_in), .vram_write(vram_write), .vram_out(vram_out),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // VRAM model: synchronous write, 1-cycle read latency
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 7200; i++) mem[i] <= i[7:0];
    end else if (vram_write && vram_address < 64'd7200) begin
      mem[vram_address[12:0]] <= vram_in;
    end
    vram_out <= (vram_address < 64'd7200) ? mem[vram_address[12:0]] : 8'h00;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: every VRAM write must match the head of exp_q
  always @(negedge clock) begin
    if (mon_en && vram_write) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", vram_address, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [20:0] e;
        e = exp_q.pop_front();
        check("wr_addr", vram_address, {51'd0, e[20:8]});
        check("wr_data", {56'd0, vram_in}, {56'd0, e[7:0]});
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input int addr, input logic [7:0] data);
    logic [12:0] a;
    a = addr[12:0];
    exp_q.push_back({a, data});
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_attr = 8'h00;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] a);
    int n;
    n = 0;
    while (!in_ready && n < 20000) begin step(); n++; end
    if (!in_ready) check("send_timeout_ready", {63'd0, in_ready}, 64'd1);
    in_data = d; in_attr = a; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (!in_ready && cycles < budget) begin step(); cycles++; end
    if (!in_ready) check("wait_idle_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    check({name, "_col"}, {57'd0, cursor_col}, col);
    check({name, "_row"}, {58'd0, cursor_row}, row);
  endtask

  initial begin
    int cyc;
    in_valid = 1'b0; in_data = 8'h00; in_attr = 8'h00; reset = 1'b1;

    // 1: reset state, then one printable
    do_reset();
    mon_en = 1'b1;
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_write", {63'd0, vram_write}, 64'd0);
    check("rst_addr", vram_address, 64'd0);
    check("rst_vram_in", {56'd0, vram_in}, 64'd0);
    check("rst_state", {61'd0, dbg_state}, 64'd0);
    check_cursor("rst", 0, 0);
    push_wr(0, 8'h41); push_wr(1, 8'h1F);
    send_byte(8'h41, 8'h1F);
    wait_idle(100, cyc);
    check("t1_busy_cycles", cyc, 2);
    check_cursor("t1", 1, 0);

    // 2: a full row of 0x42 wraps without scrolling
    do_reset();
    for (int c = 0; c < 80; c++) begin
      push_wr(2 * c, 8'h42); push_wr(2 * c + 1, 8'h33);
      send_byte(8'h42, 8'h33);
    end
    wait_idle(100, cyc);
    check("t2_last_busy", cyc, 2);
    check_cursor("t2", 0, 1);

    // 3: form feed clears the whole screen
    for (int i = 0; i < 7200; i++) push_wr(i, i[0] ? 8'h07 : 8'h20);
    send_byte(8'h0C, 8'h07);
    wait_idle(10000, cyc);
    check("t3_busy_cycles", cyc, 7200);
    check_cursor("t3", 0, 0);

    // 4: LF on the last row scrolls
    do_reset();
    preload = 1'b1; step(); preload = 1'b0;
    for (int r = 0; r < 44; r++) send_byte(8'h0A, 8'h00);
    check_cursor("t4_pre", 0, 44);
    for (int d = 0; d < 7040; d++) begin
      int s;
      s = d + 160;
      push_wr(d, s[7:0]);
    end
    for (int i = 7040; i < 7200; i++) push_wr(i, i[0] ? 8'h5A : 8'h20);
    send_byte(8'h0A, 8'h5A);
    wait_idle(20000, cyc);
    check("t4_busy_cycles", cyc, 14240);
    check_cursor("t4", 0, 44);
    step();
    check("t4_mem0", {56'd0, mem[0]}, 64'hA0);
    check("t4_mem7039", {56'd0, mem[7039]}, 64'h1F);
    check("t4_mem7040", {56'd0, mem[7040]}, 64'h20);
    check("t4_mem7199", {56'd0, mem[7199]}, 64'h5A);

    // 5: BS, CR and an ignored byte; none write VRAM
    do_reset();
    send_byte(8'h0A, 8'h00);
    check_cursor("t5_lf", 0, 1);
    send_byte(8'h08, 8'h00);
    wait_idle(100, cyc);
    check("t5_bs_busy", cyc, 0);
    check_cursor("t5_bs_wrap", 79, 0);
    send_byte(8'h0D, 8'h00);
    check_cursor("t5_cr0", 0, 0);
    send_byte(8'h08, 8'h00);
    check_cursor("t5_bs_origin", 0, 0);
    send_byte(8'h01, 8'h00);
    check("t5_other_ready", {63'd0, in_ready}, 64'd1);
    check_cursor("t5_other", 0, 0);
    for (int r = 0; r < 5; r++) send_byte(8'h0A, 8'h00);
    for (int c = 0; c < 37; c++) begin
      push_wr(2 * (400 + c), 8'h61); push_wr(2 * (400 + c) + 1, 8'h0E);
      send_byte(8'h61, 8'h0E);
    end
    wait_idle(100, cyc);
    check_cursor("t5_pre_cr", 37, 5);
    send_byte(8'h0D, 8'h00);
    check("t5_cr_ready", {63'd0, in_ready}, 64'd1);
    check_cursor("t5_cr", 0, 5);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: reset in the 100th cycle of a scroll
    do_reset();
    for (int r = 0; r < 44; r++) send_byte(8'h0A, 8'h00);
    mon_en = 1'b0;
    send_byte(8'h0A, 8'h11);
    for (int k = 0; k < 99; k++) step();
    check("t6_busy_mid", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step();
    check("t6_write_after_rst", {63'd0, vram_write}, 64'd0);
    check_cursor("t6", 0, 0);
    reset = 1'b0;
    step();
    check("t6_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    mon_en = 1'b1;
    step(); step();

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
